// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bus_pkg
// Brief   : Shared types and constants for the memory-bus arbiter and masters.
// Revision: 1.0 - initial release
// ============================================================================
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  localparam logic [31:0] c_err_data = 32'hDEADBEEF;

  typedef struct packed {
    logic        sel;
    logic [31:0] addr;
    logic        wr_en;
    logic [3:0]  wr_mask;
    logic [31:0] data;
  } bus_req_t;

endpackage
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : bus_arbiter
// Brief   : Two-master round-robin arbiter with a per-transaction watchdog.
// Revision: 1.0 - initial release
// ============================================================================
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = c_err_data
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        m0_sel_i,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_wr_en_i,
  input  logic [3:0]  m0_wr_mask_i,
  input  logic [31:0] m0_data_in_i,
  output logic [31:0] m0_data_out_o,
  output logic        m0_ack_o,
  input  logic        m1_sel_i,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_wr_en_i,
  input  logic [3:0]  m1_wr_mask_i,
  input  logic [31:0] m1_data_in_i,
  output logic [31:0] m1_data_out_o,
  output logic        m1_ack_o,
  output logic        sel_o,
  output logic [31:0] addr_o,
  output logic        wr_en_o,
  output logic [3:0]  wr_mask_o,
  output logic [31:0] data_out_o,
  input  logic [31:0] data_in_i,
  input  logic        ack_i,
  output logic        timeout_o,
  output logic [7:0]  err_count_o
);

  localparam int c_wd_width = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int c_wd_limit = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [c_wd_width-1:0] c_wd_last = c_wd_width'(c_wd_limit);

  arb_state_t            r_state;
  arb_state_t            w_next_state;
  logic                  r_last;
  logic [c_wd_width-1:0] r_wd_count;
  logic [7:0]            r_err_count;
  logic                  w_granted;
  logic                  w_timeout;
  logic                  w_done;
  bus_req_t              w_req;
  logic [31:0]           w_rdata;

  assign w_granted = (r_state == GRANT0) || (r_state == GRANT1);
  // A real ack wins over an expiring watchdog in the same cycle.
  assign w_timeout = (TIMEOUT_CYCLES != 0) && w_granted && !ack_i && (r_wd_count == c_wd_last);
  assign w_done    = w_granted && (ack_i || w_timeout);
  assign w_rdata   = ack_i ? data_in_i : ERR_DATA;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (m0_sel_i && m1_sel_i) w_next_state = r_last ? GRANT0 : GRANT1;
        else if (m0_sel_i)        w_next_state = GRANT0;
        else if (m1_sel_i)        w_next_state = GRANT1;
      end
      GRANT0, GRANT1: if (w_done) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_req         = '0;
    m0_ack_o      = 1'b0;
    m1_ack_o      = 1'b0;
    m0_data_out_o = '0;
    m1_data_out_o = '0;
    case (r_state)
      GRANT0: begin
        w_req         = '{1'b1, m0_addr_i, m0_wr_en_i, m0_wr_mask_i, m0_data_in_i};
        m0_ack_o      = w_done;
        m0_data_out_o = w_done ? w_rdata : '0;
      end
      GRANT1: begin
        w_req         = '{1'b1, m1_addr_i, m1_wr_en_i, m1_wr_mask_i, m1_data_in_i};
        m1_ack_o      = w_done;
        m1_data_out_o = w_done ? w_rdata : '0;
      end
      default: ;
    endcase
  end

  assign sel_o       = w_req.sel;
  assign addr_o      = w_req.addr;
  assign wr_en_o     = w_req.wr_en;
  assign wr_mask_o   = w_req.wr_mask;
  assign data_out_o  = w_req.data;
  assign timeout_o   = w_timeout;
  assign err_count_o = r_err_count;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_last      <= 1'b1;
      r_wd_count  <= '0;
      r_err_count <= '0;
    end else begin
      if (w_done) r_last <= (r_state == GRANT1);
      // Counter sits at zero in IDLE, so every grant starts from a clean count.
      if (!w_granted || w_done) r_wd_count <= '0;
      else                      r_wd_count <= r_wd_count + 1'b1;
      if (w_timeout && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_bus_arbiter
// Brief   : Directed self-checking bench for bus_arbiter (TIMEOUT_CYCLES = 16).
// Revision: 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        m0_sel_i, m1_sel_i;
  logic [31:0] m0_addr_i, m1_addr_i;
  logic        m0_wr_en_i, m1_wr_en_i;
  logic [3:0]  m0_wr_mask_i, m1_wr_mask_i;
  logic [31:0] m0_data_in_i, m1_data_in_i;
  logic [31:0] m0_data_out_o, m1_data_out_o;
  logic        m0_ack_o, m1_ack_o;
  logic        sel_o, wr_en_o, timeout_o;
  logic [31:0] addr_o, data_out_o, data_in_i;
  logic [3:0]  wr_mask_o;
  logic        ack_i;
  logic [7:0]  err_count_o;

  int n_checks = 0;
  int n_errors = 0;
  int n_pulses = 0;

  bus_arbiter #(.TIMEOUT_CYCLES(16), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .reset_i(reset_i),
    .m0_sel_i(m0_sel_i), .m0_addr_i(m0_addr_i), .m0_wr_en_i(m0_wr_en_i),
    .m0_wr_mask_i(m0_wr_mask_i), .m0_data_in_i(m0_data_in_i),
    .m0_data_out_o(m0_data_out_o), .m0_ack_o(m0_ack_o),
    .m1_sel_i(m1_sel_i), .m1_addr_i(m1_addr_i), .m1_wr_en_i(m1_wr_en_i),
    .m1_wr_mask_i(m1_wr_mask_i), .m1_data_in_i(m1_data_in_i),
    .m1_data_out_o(m1_data_out_o), .m1_ack_o(m1_ack_o),
    .sel_o(sel_o), .addr_o(addr_o), .wr_en_o(wr_en_o), .wr_mask_o(wr_mask_o),
    .data_out_o(data_out_o), .data_in_i(data_in_i), .ack_i(ack_i),
    .timeout_o(timeout_o), .err_count_o(err_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset_i = 1'b1;
    m0_sel_i = 0; m1_sel_i = 0; m0_wr_en_i = 0; m1_wr_en_i = 0;
    m0_addr_i = '0; m1_addr_i = '0; m0_wr_mask_i = '0; m1_wr_mask_i = '0;
    m0_data_in_i = '0; m1_data_in_i = '0; data_in_i = '0; ack_i = 0;

    // Reset state
    tick(); tick();
    settle();
    chk("rst_sel", 32'(sel_o), 32'd0);
    chk("rst_acks", {30'd0, m1_ack_o, m0_ack_o}, 32'd0);
    chk("rst_err", 32'(err_count_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    reset_i = 1'b0;

    // m0 read of 0x100, slave acks 3 cycles after sel_o
    tick();
    m0_sel_i = 1; m0_addr_i = 32'h100; m0_wr_en_i = 0;
    settle();
    chk("t1_req_sel", 32'(sel_o), 32'd0);
    tick(); settle();
    chk("t1_grant_sel", 32'(sel_o), 32'd1);
    chk("t1_addr", addr_o, 32'h100);
    chk("t1_no_ack", 32'(m0_ack_o), 32'd0);
    tick(); tick(); settle();
    chk("t1_wait_ack", 32'(m0_ack_o), 32'd0);
    tick();
    ack_i = 1; data_in_i = 32'h12345678;
    settle();
    chk("t1_ack", 32'(m0_ack_o), 32'd1);
    chk("t1_data", m0_data_out_o, 32'h12345678);
    chk("t1_m1_ack", {31'd0, m1_ack_o}, 32'd0);
    chk("t1_m1_data", m1_data_out_o, 32'd0);
    tick();
    ack_i = 0; m0_sel_i = 0;
    settle();
    chk("t1_sel_drop", 32'(sel_o), 32'd0);

    // m1 never acked: watchdog fires in the 16th grant cycle
    m1_sel_i = 1; m1_addr_i = 32'h200;
    tick(); settle();
    chk("t3_grant", {31'd0, sel_o}, 32'd1);
    for (int i = 2; i <= 15; i++) tick();
    settle();
    chk("t3_no_early", 32'(m1_ack_o), 32'd0);
    tick(); settle();
    chk("t3_ack", 32'(m1_ack_o), 32'd1);
    chk("t3_data", m1_data_out_o, 32'hDEADBEEF);
    chk("t3_pulse", 32'(timeout_o), 32'd1);
    tick();
    m1_sel_i = 0;
    settle();
    chk("t3_count", 32'(err_count_o), 32'd1);
    chk("t3_pulse_end", 32'(timeout_o), 32'd0);
    chk("t3_idle", 32'(sel_o), 32'd0);
    ack_i = 1; data_in_i = 32'h55AA55AA;
    settle();
    chk("t3_late_ack", {30'd0, m1_ack_o, m0_ack_o}, 32'd0);
    tick();
    ack_i = 0;

    // ack arriving in the cycle the watchdog would expire
    m0_sel_i = 1; m0_addr_i = 32'h300;
    for (int i = 1; i <= 16; i++) tick();
    ack_i = 1; data_in_i = 32'hCAFEF00D;
    settle();
    chk("t4_ack", 32'(m0_ack_o), 32'd1);
    chk("t4_data", m0_data_out_o, 32'hCAFEF00D);
    chk("t4_no_pulse", 32'(timeout_o), 32'd0);
    tick();
    ack_i = 0; m0_sel_i = 0;
    settle();
    chk("t4_count", 32'(err_count_o), 32'd1);

    // asynchronous reset mid-grant; last becomes m0-priority again
    m1_sel_i = 1; m1_addr_i = 32'h400;
    tick(); tick(); settle();
    chk("t5_granted", 32'(sel_o), 32'd1);
    ack_i = 1; data_in_i = 32'h11111111;
    reset_i = 1;
    settle();
    chk("t5_sel_drop", 32'(sel_o), 32'd0);
    chk("t5_no_ack", {30'd0, m1_ack_o, m0_ack_o}, 32'd0);
    chk("t5_err_clr", 32'(err_count_o), 32'd0);
    tick();
    ack_i = 0; reset_i = 0;

    // both masters continuously requesting: m0, m1, m0, m1 with idle gaps
    m0_sel_i = 1; m0_addr_i = 32'hA0; m0_wr_en_i = 0;
    m1_sel_i = 1; m1_addr_i = 32'hB0; m1_wr_en_i = 1;
    m1_wr_mask_i = 4'b0011; m1_data_in_i = 32'h0BADF00D;
    for (int t = 0; t < 4; t++) begin
      tick(); settle();
      chk("rr_sel", 32'(sel_o), 32'd1);
      chk("rr_addr", addr_o, (t % 2 == 0) ? 32'hA0 : 32'hB0);
      chk("rr_wr_en", 32'(wr_en_o), (t % 2 == 0) ? 32'd0 : 32'd1);
      chk("rr_mask", 32'(wr_mask_o), (t % 2 == 0) ? 32'd0 : 32'd3);
      chk("rr_wdata", data_out_o, (t % 2 == 0) ? 32'd0 : 32'h0BADF00D);
      ack_i = 1; data_in_i = 32'h1000 + 32'(t);
      settle();
      chk("rr_m0_ack", 32'(m0_ack_o), (t % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_m1_ack", 32'(m1_ack_o), (t % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      ack_i = 0;
      settle();
      chk("rr_gap", 32'(sel_o), 32'd0);
      chk("rr_gap_addr", addr_o, 32'd0);
    end
    m1_sel_i = 0; m1_wr_en_i = 0;

    // 300 forced timeouts from m0 (16 grant cycles + 1 idle each)
    tick();
    for (int c = 0; c < 300 * 17 + 4; c++) begin
      tick();
      if (timeout_o) n_pulses++;
    end
    m0_sel_i = 0;
    chk("sat_pulses", 32'(n_pulses), 32'd300);
    chk("sat_count", 32'(err_count_o), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
